wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back controller for the 32x32 register file (2 async read ports, 1 sync write port WE3/A3/WD3).
- Shares the single write port between two requesters, ALU and LSU, using round-robin arbitration with valid/ready handshakes.
- Drives the port from registered outputs.
- Keeps a 32-bit pending-write scoreboard, set at issue and cleared at commit, and reports RAW hazards for the decode-stage source operands.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clk  input  1  clock, rising edge
areset  input  1  reset, asynchronous, active-high
alu_valid  input  1  ALU write-back request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
lsu_valid  input  1  LSU write-back request
lsu_ready  output  1  LSU request accepted this cycle
lsu_rd  input  ADDR_W  LSU destination register
lsu_data  input  DATA_W  LSU load data
iss_valid  input  1  instruction with destination issued
iss_rd  input  ADDR_W  issued destination register
rs1  input  ADDR_W  decode source 1
rs2  input  ADDR_W  decode source 2
haz_rs1  output  1  rs1 has an uncommitted write pending
haz_rs2  output  1  rs2 has an uncommitted write pending
rf_we  output  1  to register file WE3
rf_waddr  output  ADDR_W  to A3
rf_wdata  output  DATA_W  to WD3

Behaviour:
- Reset (areset=1, async): rf_we=0, rf_waddr=0, rf_wdata=0, pending[*]=0, rr_last=LSU so the ALU wins first. Reset mid-operation drops any in-flight request and any registered write; no write reaches the register file on the edge after reset release.
- Arbitration (combinational ready):
  - Only one requester valid: it gets ready=1.
  - Both valid: grant goes to the requester not named by rr_last.
  - Neither valid: both ready=0.
  - rr_last updates to the granted requester on each handshake edge.
- Handshake: transfer occurs when valid&ready at a rising edge. The requester holds valid/rd/data stable until ready. The loser keeps valid high and is granted next cycle, so the worst-case wait is 1 cycle.
- Write port latency: a handshake at edge N puts rf_we=1, rf_waddr=rd, rf_wdata=data on the outputs for cycle N..N+1. The register file commits at edge N+1. With no handshake, rf_we=0 next cycle; waddr/wdata hold their last value.
- x0 handling: rd=0 is accepted (ready asserted normally), but rf_we stays 0 and the scoreboard is untouched.
- Scoreboard:
  - iss_valid & iss_rd!=0 sets pending[iss_rd] at the edge.
  - Commit (rf_we=1 at an edge) clears pending[rf_waddr].
  - Simultaneous set and clear of the same index: set wins, because the newer producer is outstanding.
  - pending[0] is always 0.
  - Setting an already-pending register is legal; it stays 1 and a single commit clears it.
- Hazard outputs (combinational): haz_rsN = pending[rsN]. Because pending clears only at commit, haz stays high during the rf_we cycle, when the register file still reads the old value. haz_rsN=0 whenever rsN=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs fwd_rs1, fwd_rs2 (DATA_W).
  - When rf_we=1 and rf_waddr==rsN!=0, haz_rsN is forced to 0 and fwd_rsN=rf_wdata.
  - Otherwise fwd_rsN=0.
  - Decode selects fwd over RDn on a match.
- Undefined: ports absent; haz_rsN follows pending only.

Test Plan:
1. Reset mid-stream: rf_we=1 to x5, assert areset -> rf_we=0, waddr=0, wdata=0, haz on x5=0 immediately; no write after release.
2. Single requester: alu_valid, alu_rd=3, alu_data=0xDEADBEEF at edge N -> alu_ready=1 in cycle N; rf_we=1, waddr=3, wdata=0xDEADBEEF in cycle N+1; rf_we=0 in N+2.
3. Contention: both valid for 3 cycles (alu rd=1, lsu rd=2) -> ALU granted first, LSU next, then ALU again; lsu_ready=0 in the first cycle.
4. Scoreboard: iss x7 at edge 1, rs1=7 -> haz_rs1=1 until the commit edge of an ALU write to x7; haz_rs1=0 after it. Same-edge iss x7 and commit x7 -> haz_rs1 stays 1.
5. x0: lsu_valid, rd=0, data=0x1234 -> lsu_ready=1, rf_we stays 0; iss_rd=0 -> haz_rs1 for rs1=0 stays 0.
6. WB_BYPASS_EN: pending x9, rf_we=1, waddr=9, wdata=0x55, rs2=9 -> haz_rs2=0, fwd_rs2=0x55; without the macro -> haz_rs2=1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle for wb_arbiter: ALU/LSU valid/ready requests, issue
// and decode-operand inputs, hazard outputs and the register-file write port.
// Optional macro WB_BYPASS_EN adds the fwd_rs1/fwd_rs2 forwarding outputs.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              haz_rs1;
  logic              haz_rs2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;
`endif

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, lsu_ready, haz_rs1, haz_rs2,
    output rf_we, rf_waddr, rf_wdata
`ifdef WB_BYPASS_EN
    , output fwd_rs1, fwd_rs2
`endif
  );

  // Requester / pipeline side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, lsu_ready, haz_rs1, haz_rs2,
    input  rf_we, rf_waddr, rf_wdata
`ifdef WB_BYPASS_EN
    , input fwd_rs1, fwd_rs2
`endif
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back controller: round-robin shares the single register-file write
// port between ALU and LSU, drives it from registers, and tracks pending
// destination writes to flag RAW hazards on the decode source operands.
// Optional macro WB_BYPASS_EN: forwards the in-flight write data to decode.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         areset,
  wb_arbiter_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {SRC_ALU, SRC_LSU} src_e;

  src_e              rr_last;
  logic              alu_gnt;
  logic              lsu_gnt;
  logic              alu_hs;
  logic              lsu_hs;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              haz1;
  logic              haz2;

  // Round-robin grant: a lone requester always wins, on contention the one
  // not granted last time wins.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (bus.alu_valid && bus.lsu_valid) begin
      if (rr_last == SRC_LSU) alu_gnt = 1'b1;
      else                    lsu_gnt = 1'b1;
    end else begin
      alu_gnt = bus.alu_valid;
      lsu_gnt = bus.lsu_valid;
    end
  end

  assign alu_hs        = bus.alu_valid & alu_gnt;
  assign lsu_hs        = bus.lsu_valid & lsu_gnt;
  assign bus.alu_ready = alu_gnt;
  assign bus.lsu_ready = lsu_gnt;

  // Registered write port and round-robin pointer; x0 targets are accepted
  // but never produce a write strobe.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rr_last <= SRC_LSU;
    end else begin
      we_q <= 1'b0;
      if (alu_hs) begin
        rr_last <= SRC_ALU;
        if (bus.alu_rd != '0) begin
          we_q    <= 1'b1;
          waddr_q <= bus.alu_rd;
          wdata_q <= bus.alu_data;
        end
      end else if (lsu_hs) begin
        rr_last <= SRC_LSU;
        if (bus.lsu_rd != '0) begin
          we_q    <= 1'b1;
          waddr_q <= bus.lsu_rd;
          wdata_q <= bus.lsu_data;
        end
      end
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

  // Scoreboard update: commit clears first so a same-edge issue of the same
  // register leaves it pending (the newer producer is still outstanding).
  always_comb begin
    pending_nxt = pending;
    if (we_q) pending_nxt[waddr_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) pending_nxt[bus.iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Hazard (and optional forwarding) lookup for the decode operands.
  always_comb begin
    haz1 = pending[bus.rs1];
    haz2 = pending[bus.rs2];
`ifdef WB_BYPASS_EN
    bus.fwd_rs1 = '0;
    bus.fwd_rs2 = '0;
    if (we_q && (waddr_q == bus.rs1) && (bus.rs1 != '0)) begin
      haz1        = 1'b0;
      bus.fwd_rs1 = wdata_q;
    end
    if (we_q && (waddr_q == bus.rs2) && (bus.rs2 != '0)) begin
      haz2        = 1'b0;
      bus.fwd_rs2 = wdata_q;
    end
`endif
  end

  assign bus.haz_rs1 = haz1;
  assign bus.haz_rs2 = haz2;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-cycle vector table for grants and
// hazards, plus a queue of expected register-file writes checked as they
// appear, and hand sequences for reset mid-write and forwarding.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic areset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_ar; logic e_lr; logic e_h1; logic e_h2;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t  q[$];
  wr_t  cur;
  int   cur_cyc = -1;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected write landing in the current cycle hits this operand.
  function automatic logic byp(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
    return (cur_cyc == cyc) && (cur.addr == rs) && (rs != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Write-port monitor: every strobe must match the oldest expected write
  // in the exact cycle it is due.
  always @(negedge clk) begin
    if (!areset) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_write: got none expected x%0d=%h", q[0].addr, q[0].data);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        cur     = q[0];
        cur_cyc = cyc;
      end
      if (bus.rf_we) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, q[0].addr});
          chk("rf_wdata", bus.rf_wdata, q[0].data);
          void'(q.pop_front());
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got x%0d=%h expected none", bus.rf_waddr, bus.rf_wdata);
        end
      end
    end
  end

  task automatic drive(input vec_t t);
    bus.alu_valid = t.av; bus.alu_rd = t.ard; bus.alu_data = t.ad;
    bus.lsu_valid = t.lv; bus.lsu_rd = t.lrd; bus.lsu_data = t.ld;
    bus.iss_valid = t.iv; bus.iss_rd = t.ird;
    bus.rs1 = t.r1; bus.rs2 = t.r2;
  endtask

  task automatic step(input vec_t t, input string tag);
    wr_t w;
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, "_alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, t.e_ar});
    chk({tag, "_lsu_ready"}, {31'd0, bus.lsu_ready}, {31'd0, t.e_lr});
    chk({tag, "_haz_rs1"}, {31'd0, bus.haz_rs1}, {31'd0, t.e_h1 & ~byp(t.r1)});
    chk({tag, "_haz_rs2"}, {31'd0, bus.haz_rs2}, {31'd0, t.e_h2 & ~byp(t.r2)});
`ifdef WB_BYPASS_EN
    chk({tag, "_fwd_rs1"}, bus.fwd_rs1, byp(t.r1) ? cur.data : 32'd0);
    chk({tag, "_fwd_rs2"}, bus.fwd_rs2, byp(t.r2) ? cur.data : 32'd0);
`endif
    if (t.av && t.e_ar && t.ard != 5'd0) begin
      w.addr = t.ard; w.data = t.ad; w.due = cyc + 1; q.push_back(w);
    end
    if (t.lv && t.e_lr && t.lrd != 5'd0) begin
      w.addr = t.lrd; w.data = t.ld; w.due = cyc + 1; q.push_back(w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = '{0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0};
    //         av ard ad            lv lrd ld            iv ird r1 r2  ar lr h1 h2
    tbl[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 0, 0,  1, 2,  1, 0, 0, 0};
    tbl[2]  = '{1, 1, 32'h0000A11B, 1, 2, 32'hB2B2B2B2, 0, 0,  1, 2,  0, 1, 0, 0};
    tbl[3]  = '{1, 1, 32'h0000A11B, 1, 2, 32'hCCCC0002, 0, 0,  0, 0,  1, 0, 0, 0};
    tbl[4]  = '{0, 0, 32'h0,        1, 2, 32'hCCCC0002, 0, 0,  0, 0,  0, 1, 0, 0};
    tbl[5]  = '{1, 3, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  3, 0,  1, 0, 0, 0};
    tbl[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 0,  0, 0, 0, 0};
    tbl[7]  = '{0, 0, 32'h0,        1, 4, 32'h00000044, 0, 0,  0, 0,  0, 1, 0, 0};
    tbl[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  7, 0,  0, 0, 0, 0};
    tbl[9]  = '{1, 7, 32'h00000077, 0, 0, 32'h0,        0, 0,  7, 0,  1, 0, 1, 0};
    tbl[10] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0,  0, 0, 1, 0};
    tbl[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  7, 0,  0, 0, 0, 0};
    tbl[12] = '{1, 7, 32'h00000078, 0, 0, 32'h0,        0, 0,  7, 0,  1, 0, 1, 0};
    tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  7, 0,  0, 0, 1, 0};
    tbl[14] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 7,  0, 0, 1, 1};
    tbl[15] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  7, 0,  0, 0, 1, 0};
    tbl[16] = '{1, 7, 32'h00000079, 0, 0, 32'h0,        0, 0,  7, 0,  1, 0, 1, 0};
    tbl[17] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0,  0, 0, 1, 0};
    tbl[18] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0,  0, 0, 0, 0};
    tbl[19] = '{0, 0, 32'h0,        1, 0, 32'h00001234, 1, 0,  0, 0,  0, 1, 0, 0};
    tbl[20] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0,  0, 0, 0, 0};
    tbl[21] = '{1, 0, 32'h0,        1, 5, 32'h00000055, 0, 0,  0, 5,  1, 0, 0, 0};
    tbl[22] = '{0, 0, 32'h0,        1, 5, 32'h00000055, 0, 0,  0, 5,  0, 1, 0, 0};
    tbl[23] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0,  0, 0, 0, 0};

    // Reset state
    drive(idle);
    #2;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_haz_rs1", {31'd0, bus.haz_rs1}, 32'd0);
    @(negedge clk);
    areset = 1'b0;

    for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("v%0d", i));

    // Reset while a write to x5 is on the port
    step('{0,0,32'h0, 0,0,32'h0, 1,5, 5,0, 0,0,0,0}, "r_iss");
    step('{1,5,32'h5A5A5A5A, 0,0,32'h0, 0,0, 5,0, 1,0,1,0}, "r_req");
    @(negedge clk);
    drive(idle);
    bus.rs1 = 5'd5;
    #1;
    areset = 1'b1;
    q.delete();
    cur_cyc = -1;
    #1;
    chk("midrst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("midrst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("midrst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("midrst_haz_rs1", {31'd0, bus.haz_rs1}, 32'd0);
    @(negedge clk);
    areset = 1'b0;
    step('{0,0,32'h0, 0,0,32'h0, 0,0, 5,0, 0,0,0,0}, "r_rel");
    step('{1,8,32'h00000088, 1,9,32'h00000099, 0,0, 5,0, 1,0,0,0}, "r_rr");
    step('{0,0,32'h0, 1,9,32'h00000099, 0,0, 0,0, 0,1,0,0}, "r_rr2");

    // Forwarding window on x9
    step('{0,0,32'h0, 0,0,32'h0, 1,9, 0,9, 0,0,0,0}, "b_iss");
    step('{1,9,32'h00000055, 0,0,32'h0, 0,0, 0,9, 1,0,0,1}, "b_req");
    step('{0,0,32'h0, 0,0,32'h0, 0,0, 9,9, 0,0,1,1}, "b_we");
    step('{0,0,32'h0, 0,0,32'h0, 0,0, 9,9, 0,0,0,0}, "b_done");

    for (int i = 0; i < 3; i++) step(idle, "drain");
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
